nor_gate_checker: RTL

- Self-checking stimulus/response stage wrapped around a 2-input switch-level gate such as the NOR cell.
- Drives the gate inputs A and B and consumes its output y.
- Each run sweeps all four input vectors, waits a programmable settle time per vector, then compares y against the expected truth-table value.
- Reports an error count, the first failing vector, and a pass/fail flag for bring-up of the switch-level gate library.

---
 rtl/nor_gate_checker.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/nor_gate_checker.sv
// ---------------------------------------------------------------------------------------------
// nor_gate_checker
//
// Stimulus/response checker for a 2-input gate cell such as the NOR. Each run sweeps {A,B}
// through 00, 01, 10, 11 for PASSES sweeps. Each vector is held for SETTLE_CYCLES cycles, and
// then y is sampled for one cycle and compared with the truth table selected by func.
//
// Ports:
//   clk            - clock, all state changes on the rising edge
//   rst_n          - asynchronous active-low reset
//   start          - run request, only looked at while idle
//   func           - expected function, latched at start: 00 NOR, 01 NAND, 10 AND, 11 OR
//   A, B           - registered gate inputs
//   y              - gate output under test
//   busy           - high from the start-accept edge until the end of the DONE cycle
//   done           - one-cycle pulse at the end of a run
//   pass           - last run had zero mismatches; held until the next start
//   err_count      - saturating mismatch count
//   first_fail_vec - {A,B} of the first mismatch in the run
//   fail_valid     - first_fail_vec holds a captured vector
// ---------------------------------------------------------------------------------------------
module nor_gate_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned PASSES        = 1,
    parameter int unsigned ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       func,
    output logic             A,
    output logic             B,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       first_fail_vec,
    output logic             fail_valid
);

    localparam int unsigned CntW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned PassW = (PASSES > 1) ? $clog2(PASSES) : 1;

    localparam logic [CntW-1:0]  SettleLast = CntW'(SETTLE_CYCLES - 1);
    localparam logic [PassW-1:0] PassLast   = PassW'(PASSES - 1);
    localparam logic [ERR_W-1:0] ErrMax     = '1;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSample,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    settle_cnt_q, settle_cnt_d;
    logic [PassW-1:0]   pass_cnt_q, pass_cnt_d;
    logic [1:0]         vec_q, vec_d;
    logic [1:0]         func_q, func_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [1:0]         ffv_q, ffv_d;
    logic               fv_q, fv_d;

    logic               exp_y;
    logic               mismatch;
    logic               last_vec;

    // Truth table of the function being checked, indexed by the current {A,B}.
    always_comb begin
        exp_y = 1'b0;
        unique case (func_q)
            2'b00:   exp_y = ~(vec_q[1] | vec_q[0]);
            2'b01:   exp_y = ~(vec_q[1] & vec_q[0]);
            2'b10:   exp_y = vec_q[1] & vec_q[0];
            default: exp_y = vec_q[1] | vec_q[0];
        endcase
    end

    // Case inequality so that an X or Z on y counts as a mismatch in simulation.
    assign mismatch = (y !== exp_y);
    assign last_vec = (vec_q == 2'b11) && (pass_cnt_q == PassLast);

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        pass_cnt_d   = pass_cnt_q;
        vec_d        = vec_q;
        func_d       = func_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        err_d        = err_q;
        ffv_d        = ffv_q;
        fv_d         = fv_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    func_d       = func;
                    vec_d        = 2'b00;
                    pass_cnt_d   = '0;
                    settle_cnt_d = '0;
                    err_d        = '0;
                    pass_d       = 1'b0;
                    fv_d         = 1'b0;
                    ffv_d        = 2'b00;
                    busy_d       = 1'b1;
                    state_d      = StSettle;
                end
            end

            StSettle: begin
                if (settle_cnt_q == SettleLast) begin
                    settle_cnt_d = '0;
                    state_d      = StSample;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end

            StSample: begin
                if (mismatch) begin
                    if (err_q != ErrMax) begin
                        err_d = err_q + 1'b1;
                    end
                    // A saturated counter still allows the first failure to be captured.
                    if (!fv_q) begin
                        ffv_d = vec_q;
                        fv_d  = 1'b1;
                    end
                end

                if (last_vec) begin
                    done_d  = 1'b1;
                    // Uses the count including this sample's result.
                    pass_d  = (err_d == '0);
                    state_d = StDone;
                end else begin
                    vec_d = vec_q + 2'b01;
                    if (vec_q == 2'b11) begin
                        pass_cnt_d = pass_cnt_q + 1'b1;
                    end
                    state_d = StSettle;
                end
            end

            StDone: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                vec_d   = 2'b00;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            settle_cnt_q <= '0;
            pass_cnt_q   <= '0;
            vec_q        <= 2'b00;
            func_q       <= 2'b00;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            ffv_q        <= 2'b00;
            fv_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            pass_cnt_q   <= pass_cnt_d;
            vec_q        <= vec_d;
            func_q       <= func_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            err_q        <= err_d;
            ffv_q        <= ffv_d;
            fv_q         <= fv_d;
        end
    end

    assign A              = vec_q[1];
    assign B              = vec_q[0];
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_fail_vec = ffv_q;
    assign fail_valid     = fv_q;

endmodule
